// File: rtl/ram_dp_sr_sw_pipe_if.sv
// Port bundle for ram_dp_sr_sw_pipe: one write port, one read port, clear and status.
interface ram_dp_sr_sw_pipe_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0] address_0;
    logic [DATA_WIDTH-1:0] data_0;
    logic                  cs_0;
    logic                  we_0;
    logic [ADDR_WIDTH-1:0] address_1;
    logic                  cs_1;
    logic                  oe_1;
    logic                  clear;
    logic [DATA_WIDTH-1:0] data_1;
    logic                  valid_1;
    logic                  busy;

    modport master (
        output address_0, data_0, cs_0, we_0, address_1, cs_1, oe_1, clear,
        input  data_1, valid_1, busy
    );

    modport slave (
        input  address_0, data_0, cs_0, we_0, address_1, cs_1, oe_1, clear,
        output data_1, valid_1, busy
    );
endinterface

// File: rtl/ram_dp_sr_sw_pipe.sv
// Dual-port RAM (1 write, 1 read) with self-zeroing init sweep and pipelined registered read.
// Latency: data_1/valid_1 appear RD_LATENCY cycles after the read is presented; one read per cycle.
// Backpressure: none; while busy (init sweep) all port requests are dropped.
module ram_dp_sr_sw_pipe #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 3,
    parameter int RAM_DEPTH  = 8,
    parameter int RD_LATENCY = 1,
    parameter int BYPASS     = 1
) (
    input  logic               clk,
    input  logic               rst,
    ram_dp_sr_sw_pipe_if.slave bus
);
    typedef enum logic {INIT, READY} state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_CMP = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  wr_in_range, rd_in_range;
    logic                  wr_en, rd_en;
    logic [DATA_WIDTH-1:0] rd_dat;
    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_dat;

    assign wr_in_range = {1'b0, bus.address_0} < DEPTH_CMP;
    assign rd_in_range = {1'b0, bus.address_1} < DEPTH_CMP;
    assign wr_en       = (state == READY) && bus.cs_0 && bus.we_0 && wr_in_range;
    assign rd_en       = (state == READY) && bus.cs_1 && bus.oe_1;
    assign bus.busy    = (state == INIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            INIT: begin
                if (ptr == LAST_PTR) begin
                    state_nxt = READY;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            READY: begin
                if (bus.clear) begin
                    state_nxt = INIT;
                    ptr_nxt   = '0;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    // The sweep owns the array while busy; user writes only land in READY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[ptr] <= '0;
            end else if (wr_en) begin
                mem[bus.address_0] <= bus.data_0;
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        if (rd_in_range) begin
            if (BYPASS != 0 && wr_en && bus.address_0 == bus.address_1) begin
                rd_dat = bus.data_0;
            end else begin
                rd_dat = mem[bus.address_1];
            end
        end
    end

    // Data is zeroed alongside valid so data_1 reads 0 whenever nothing completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= rd_en;
            s1_dat <= rd_en ? rd_dat : '0;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  s2_vld;
            logic [DATA_WIDTH-1:0] s2_dat;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_vld <= 1'b0;
                    s2_dat <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    s2_dat <= s1_dat;
                end
            end

            assign bus.valid_1 = s2_vld;
            assign bus.data_1  = s2_dat;
        end else begin : g_lat1
            assign bus.valid_1 = s1_vld;
            assign bus.data_1  = s1_dat;
        end
    endgenerate
endmodule

// File: tb/tb_ram_dp_sr_sw_pipe.sv
// Scoreboard bench: two DUT configs (depth 8/lat 1/bypass vs depth 6/lat 2/no bypass) share one stimulus stream.
module tb_ram_dp_sr_sw_pipe;
    localparam int DW = 12;
    localparam int AW = 3;

    typedef struct {
        int dat;
        int due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] a0 = '0;
    logic [AW-1:0] a1 = '0;
    logic [DW-1:0] d0 = '0;
    logic          cs0 = 1'b0, we0 = 1'b0, cs1 = 1'b0, oe1 = 1'b0, clr = 1'b0;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   checking = 1'b0;
    int   mem_m [2][8];
    int   left_m [2];
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    ram_dp_sr_sw_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
    ram_dp_sr_sw_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();

    assign ifa.address_0 = a0;  assign ifb.address_0 = a0;
    assign ifa.data_0    = d0;  assign ifb.data_0    = d0;
    assign ifa.cs_0      = cs0; assign ifb.cs_0      = cs0;
    assign ifa.we_0      = we0; assign ifb.we_0      = we0;
    assign ifa.address_1 = a1;  assign ifb.address_1 = a1;
    assign ifa.cs_1      = cs1; assign ifb.cs_1      = cs1;
    assign ifa.oe_1      = oe1; assign ifb.oe_1      = oe1;
    assign ifa.clear     = clr; assign ifb.clear     = clr;

    ram_dp_sr_sw_pipe #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(8), .RD_LATENCY(1), .BYPASS(1)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );

    ram_dp_sr_sw_pipe #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(6), .RD_LATENCY(2), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    always #5 clk = ~clk;

    function automatic int dep(int d); return (d == 0) ? 8 : 6; endfunction
    function automatic int lat(int d); return (d == 0) ? 1 : 2; endfunction
    function automatic int byp(int d); return (d == 0) ? 1 : 0; endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: applies the inputs sampled at this edge, then returns at the negedge for new stimulus.
    task automatic step();
        exp_t e;
        int   issue;
        @(posedge clk);
        issue = cyc;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                left_m[d] = dep(d);
                for (int i = 0; i < 8; i++) mem_m[d][i] = 0;
            end else if (left_m[d] > 0) begin
                left_m[d]--;
            end else begin
                if (cs1 && oe1) begin
                    e.due = issue + lat(d);
                    e.dat = 0;
                    if (int'(a1) < dep(d))
                        e.dat = (byp(d) == 1 && cs0 && we0 && a0 == a1) ? int'(d0) : mem_m[d][a1];
                    if (d == 0) qa.push_back(e);
                    else        qb.push_back(e);
                end
                if (cs0 && we0 && int'(a0) < dep(d)) mem_m[d][a0] = int'(d0);
                if (clr) begin
                    left_m[d] = dep(d);
                    for (int i = 0; i < 8; i++) mem_m[d][i] = 0;
                end
            end
        end
        if (rst) begin
            qa.delete();
            qb.delete();
            checking = 1'b1;
        end
        @(negedge clk);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (checking) begin
            chk("busy_a", {31'b0, ifa.busy}, (left_m[0] > 0) ? 32'd1 : 32'd0);
            if (ifa.valid_1 === 1'b1) begin
                if (qa.size() == 0) begin
                    chk("spurious_valid_a", {31'b0, ifa.valid_1}, 32'd0);
                end else begin
                    ea = qa.pop_front();
                    chk("latency_a", 32'(cyc), 32'(ea.due));
                    chk("data_a", 32'(ifa.data_1), 32'(ea.dat));
                end
            end else begin
                chk("idle_zero_a", 32'(ifa.data_1), 32'd0);
                if (qa.size() > 0 && qa[0].due <= cyc) begin
                    chk("missing_valid_a", {31'b0, ifa.valid_1}, 32'd1);
                    void'(qa.pop_front());
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (checking) begin
            chk("busy_b", {31'b0, ifb.busy}, (left_m[1] > 0) ? 32'd1 : 32'd0);
            if (ifb.valid_1 === 1'b1) begin
                if (qb.size() == 0) begin
                    chk("spurious_valid_b", {31'b0, ifb.valid_1}, 32'd0);
                end else begin
                    eb = qb.pop_front();
                    chk("latency_b", 32'(cyc), 32'(eb.due));
                    chk("data_b", 32'(ifb.data_1), 32'(eb.dat));
                end
            end else begin
                chk("idle_zero_b", 32'(ifb.data_1), 32'd0);
                if (qb.size() > 0 && qb[0].due <= cyc) begin
                    chk("missing_valid_b", {31'b0, ifb.valid_1}, 32'd1);
                    void'(qb.pop_front());
                end
            end
        end
    end

    task automatic idle();
        cs0 = 1'b0; we0 = 1'b0; cs1 = 1'b0; oe1 = 1'b0; clr = 1'b0;
    endtask

    task automatic do_wr(int a, int d);
        cs0 = 1'b1; we0 = 1'b1; a0 = AW'(a); d0 = DW'(d);
    endtask

    task automatic do_rd(int a);
        cs1 = 1'b1; oe1 = 1'b1; a1 = AW'(a);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        idle();
        while ((left_m[0] > 0 || left_m[1] > 0) && n < 30) begin
            step();
            n++;
        end
        chk("ready_busy_a", {31'b0, ifa.busy}, 32'd0);
        chk("ready_busy_b", {31'b0, ifb.busy}, 32'd0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i++) begin
            idle();
            do_rd(i);
            step();
        end
        idle();
        step(); step(); step();
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        idle();
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        read_all();

        do_wr(3, 'hABC); step();
        idle(); do_rd(3); step();
        idle(); step(); step(); step();

        do_wr(5, 'h456); step();
        idle(); do_wr(5, 'h123); do_rd(5); step();
        idle(); step(); step(); step();

        do_wr(7, 'h777); step();
        idle(); do_rd(7); step();
        idle(); step(); step(); step();

        for (int i = 0; i < 8; i++) begin idle(); do_wr(i, 'h100 + i); step(); end
        idle(); do_rd(2); clr = 1'b1; step();
        idle(); do_wr(4, 'hFFF); do_rd(4); step();
        wait_ready();
        read_all();

        for (int i = 0; i < 8; i++) begin idle(); do_wr(i, 'h200 + i); step(); end
        idle(); clr = 1'b1; step();
        idle();
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1; step();
        rst = 1'b0;
        wait_ready();
        read_all();

        for (int i = 0; i < 600; i++) begin
            idle();
            cs0 = 1'($urandom_range(0, 1));
            we0 = 1'($urandom_range(0, 1));
            a0  = AW'($urandom_range(0, 7));
            d0  = DW'($urandom);
            cs1 = 1'($urandom_range(0, 3) != 0);
            oe1 = 1'($urandom_range(0, 3) != 0);
            a1  = ($urandom_range(0, 2) == 0) ? a0 : AW'($urandom_range(0, 7));
            clr = 1'($urandom_range(0, 39) == 0);
            rst = 1'($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < 6; i++) step();
        chk("drain_a", 32'(qa.size()), 32'd0);
        chk("drain_b", 32'(qb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_dp_sr_sw_pipe.md
RAM_DP_SR_SW_PIPE -- requirements
Module: ram_dp_sr_sw_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, address width in bits.
REQ-003 SHALL have parameter RAM_DEPTH, default 8, number of words; legal range 2..2**ADDR_WIDTH.
REQ-004 SHALL have parameter RD_LATENCY, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have parameter BYPASS, default 1, read-during-write mode: 1 returns new data, 0 returns old data.
REQ-006 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port address_0  input  ADDR_WIDTH  write address.
REQ-009 SHALL have port data_0  input  DATA_WIDTH  write data.
REQ-010 SHALL have port cs_0  input  1  write-port chip select.
REQ-011 SHALL have port we_0  input  1  write enable.
REQ-012 SHALL have port address_1  input  ADDR_WIDTH  read address.
REQ-013 SHALL have port cs_1  input  1  read-port chip select.
REQ-014 SHALL have port oe_1  input  1  read output enable.
REQ-015 SHALL have port clear  input  1  request to zero the whole array.
REQ-016 SHALL have port data_1  output  DATA_WIDTH  read data, registered.
REQ-017 SHALL have port valid_1  output  1  data_1 holds a completed read this cycle.
REQ-018 SHALL have port busy  output  1  array initialisation in progress; ports ignored.

Function
REQ-019 SHALL implement a two-state FSM: INIT and READY.
REQ-020 In INIT, SHALL write zero to one word per cycle, sweep pointer 0 to RAM_DEPTH-1, then enter READY on the cycle after writing word RAM_DEPTH-1; INIT lasts exactly RAM_DEPTH cycles.
REQ-021 SHALL assert busy exactly while in INIT.
REQ-022 In READY, clear=1 SHALL enter INIT on the next edge with the sweep pointer at 0; clear while in INIT SHALL be ignored.
REQ-023 In INIT, user writes and reads SHALL be ignored and no read SHALL be issued.
REQ-024 Write: in READY with cs_0=1, we_0=1 and address_0<RAM_DEPTH, mem[address_0] SHALL take data_0 at the edge.
REQ-025 A write with address_0>=RAM_DEPTH SHALL be dropped without modifying the array.
REQ-026 Read issue: in READY with cs_1=1 and oe_1=1, a read SHALL be issued; one read SHALL be accepted per cycle, with no stall.
REQ-027 An issued read SHALL present data_1 with valid_1=1 exactly RD_LATENCY cycles after the issue edge, for one cycle per read.
REQ-028 When valid_1=0, data_1 SHALL be 0.
REQ-029 A read with address_1>=RAM_DEPTH SHALL complete with valid_1=1 and data_1=0.
REQ-030 Same-cycle write and read to the same in-range address: BYPASS=1 SHALL return data_0; BYPASS=0 SHALL return the pre-write contents.
REQ-031 With RD_LATENCY=2, the read pipeline SHALL be fully pipelined: back-to-back issues SHALL yield back-to-back valid_1 in issue order.
REQ-032 Reads in flight when clear is accepted SHALL still complete with the data sampled at issue.
REQ-033 Write-then-read of the same address in consecutive cycles SHALL return the newly written data.

Reset
REQ-034 rst=1 SHALL force the FSM to INIT with sweep pointer 0, flush the read pipeline, and drive valid_1=0, data_1=0 and busy=1 from the next edge.
REQ-035 rst asserted mid-INIT SHALL restart the sweep at word 0; rst has priority over every other input.
REQ-036 Array contents SHALL be all zero once busy deasserts after reset.

Verification
REQ-037 Reset, then idle: busy=1 for exactly RAM_DEPTH (8) cycles; a read of each address then returns 0 with valid_1=1.
REQ-038 RD_LATENCY=1: write 0xABC to address 3, read address 3 next cycle -> data_1=0xABC and valid_1=1 one cycle after issue; data_1=0 on the following cycle.
REQ-039 Same-cycle write 0x123 and read of address 5 (old value 0x456) -> data_1=0x123 with BYPASS=1, 0x456 with BYPASS=0.
REQ-040 RD_LATENCY=2: issue reads of addresses 0,1,2 on back-to-back cycles -> three consecutive valid_1 pulses starting 2 cycles after the first issue, in order.
REQ-041 Fill the array, pulse clear, then write during busy -> write dropped; all reads after busy falls return 0.
REQ-042 Assert rst at INIT cycle 4 -> busy remains high for 8 further cycles; the array is all zero afterwards.
